// File: rtl/pe_tile_sequencer_if.sv
// Handshake and SRAM/PE-array bus between the tile sequencer and its neighbours.
// master = sequencer side, slave = the SRAMs, PE array and result writer.
interface pe_tile_sequencer_if #(
    parameter int W_ADDR_WIDTH = 10,
    parameter int V_ADDR_WIDTH = 10,
    parameter int TILE_WIDTH   = 4
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    sram_ren_w;
    logic [W_ADDR_WIDTH-1:0] sram_raddr_w;
    logic                    sram_ren_v;
    logic [V_ADDR_WIDTH-1:0] sram_raddr_v;
    logic                    alu_start;
    logic [8:0]              cycle_num;
    logic                    pe_srstn;
    logic                    result_valid;
    logic [TILE_WIDTH-1:0]   result_tile;
    logic                    result_ready;

    modport master (
        input  start,
        input  result_ready,
        output busy,
        output done,
        output sram_ren_w,
        output sram_raddr_w,
        output sram_ren_v,
        output sram_raddr_v,
        output alu_start,
        output cycle_num,
        output pe_srstn,
        output result_valid,
        output result_tile
    );

    modport slave (
        output start,
        output result_ready,
        input  busy,
        input  done,
        input  sram_ren_w,
        input  sram_raddr_w,
        input  sram_ren_v,
        input  sram_raddr_v,
        input  alu_start,
        input  cycle_num,
        input  pe_srstn,
        input  result_valid,
        input  result_tile
    );
endinterface

// File: rtl/pe_tile_sequencer.sv
// Tile sequencer in front of the PE vector-matrix array: per tile it clears the
// accumulators, streams K weight/vector read pairs, lines alu_start/cycle_num up
// with the SRAM read data and holds the finished tile until the writer takes it.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; PE array out of reset
// CLEAR  | one cycle of PE accumulator clear (pe_srstn low)
// FETCH  | K read pairs, k = 0..K-1
// DRAIN  | reads stopped; last beats travel through SRAM and the PE
// WRITE  | result_valid held with result_tile until result_ready
// DONE   | one-cycle done pulse, then back to IDLE
module pe_tile_sequencer #(
    parameter int ARRAY_SIZE    = 16,
    parameter int K_ACCUM_DEPTH = 32,
    parameter int NUM_TILES     = 4,
    parameter int SRAM_LATENCY  = 1,
    parameter int W_ADDR_WIDTH  = 10,
    parameter int V_ADDR_WIDTH  = 10,
    parameter int TILE_WIDTH    = 4
) (
    input logic                 clk,
    input logic                 srstn,
    pe_tile_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // DRAIN covers the SRAM read latency plus two cycles so the PE array has
    // registered the final accumulate beat before result_valid is raised.
    localparam int DRAIN_CYCLES = SRAM_LATENCY + 2;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

    localparam logic [8:0]            K_LAST     = 9'(K_ACCUM_DEPTH - 1);
    localparam logic [TILE_WIDTH-1:0] TILE_LAST  = TILE_WIDTH'(NUM_TILES - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    if (ARRAY_SIZE < 1 || K_ACCUM_DEPTH < 2 || K_ACCUM_DEPTH > 512 ||
        NUM_TILES < 1 || NUM_TILES > (1 << TILE_WIDTH) || SRAM_LATENCY < 1) begin : g_param_check
        $error("pe_tile_sequencer: parameter out of range");
    end

    logic [2:0]              state_q, state_d;
    logic [8:0]              k_q, k_d;
    logic [TILE_WIDTH-1:0]   tile_q, tile_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pe_srstn_q, pe_srstn_d;
    logic                    ren_q, ren_d;
    logic [W_ADDR_WIDTH-1:0] raddr_w_q, raddr_w_d;
    logic [V_ADDR_WIDTH-1:0] raddr_v_q, raddr_v_d;
    logic                    result_valid_q, result_valid_d;
    logic [TILE_WIDTH-1:0]   result_tile_q, result_tile_d;

    // Alignment pipe: stage 0 sees the read issued this cycle, the last
    // stage lines up with the returning rdata and drives the PE directly.
    logic [SRAM_LATENCY-1:0]       pipe_ren_q, pipe_ren_d;
    logic [SRAM_LATENCY-1:0][8:0]  pipe_k_q, pipe_k_d;

    // Sequencing: state transitions, accumulation index, tile index, drain timer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tile_d  = tile_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    tile_d  = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FETCH;
                k_d     = '0;
            end
            S_FETCH: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                    drain_d = DRAIN_LOAD;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            S_WRITE: begin
                if (bus.result_ready) begin
                    if (tile_q == TILE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                        tile_d  = tile_q + TILE_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered value shows
    // up in exactly the cycles the FSM sits in that state.
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        pe_srstn_d     = (state_d != S_CLEAR);
        ren_d          = (state_d == S_FETCH);
        raddr_w_d      = '0;
        raddr_v_d      = '0;
        result_valid_d = (state_d == S_WRITE);
        result_tile_d  = '0;
        if (ren_d) begin
            // Width-limited arithmetic gives the modulo-2^width address wrap.
            raddr_w_d = W_ADDR_WIDTH'(tile_d) * W_ADDR_WIDTH'(K_ACCUM_DEPTH) + W_ADDR_WIDTH'(k_d);
            raddr_v_d = V_ADDR_WIDTH'(k_d);
        end
        if (result_valid_d) begin
            result_tile_d = tile_d;
        end
    end

    // Shift the issued {ren, k} along; k is zeroed when no read was issued so
    // cycle_num idles at 0.
    always_comb begin
        pipe_ren_d    = '0;
        pipe_k_d      = '0;
        pipe_ren_d[0] = ren_q;
        pipe_k_d[0]   = ren_q ? k_q : 9'd0;
        for (int i = 1; i < SRAM_LATENCY; i++) begin
            pipe_ren_d[i] = pipe_ren_q[i-1];
            pipe_k_d[i]   = pipe_k_q[i-1];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            tile_q         <= '0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pe_srstn_q     <= 1'b0;
            ren_q          <= 1'b0;
            raddr_w_q      <= '0;
            raddr_v_q      <= '0;
            result_valid_q <= 1'b0;
            result_tile_q  <= '0;
            pipe_ren_q     <= '0;
            pipe_k_q       <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            tile_q         <= tile_d;
            drain_q        <= drain_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pe_srstn_q     <= pe_srstn_d;
            ren_q          <= ren_d;
            raddr_w_q      <= raddr_w_d;
            raddr_v_q      <= raddr_v_d;
            result_valid_q <= result_valid_d;
            result_tile_q  <= result_tile_d;
            pipe_ren_q     <= pipe_ren_d;
            pipe_k_q       <= pipe_k_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pe_srstn     = pe_srstn_q;
    assign bus.sram_ren_w   = ren_q;
    assign bus.sram_ren_v   = ren_q;
    assign bus.sram_raddr_w = raddr_w_q;
    assign bus.sram_raddr_v = raddr_v_q;
    assign bus.alu_start    = pipe_ren_q[SRAM_LATENCY-1];
    assign bus.cycle_num    = pipe_k_q[SRAM_LATENCY-1];
    assign bus.result_valid = result_valid_q;
    assign bus.result_tile  = result_tile_q;

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Bench for pe_tile_sequencer: several parameterisations run side by side on
// shared start/srstn, each with its own result_ready, a timeline model and
// literal timing expectations for the directed jobs.
module tb_pe_tile_sequencer;

    localparam int NCFG = 5;
    localparam int CFG_K [NCFG] = '{32, 32, 32, 32, 2};
    localparam int CFG_L [NCFG] = '{1, 1, 3, 2, 1};
    localparam int CFG_N [NCFG] = '{1, 3, 1, 3, 2};
    localparam int CFG_W [NCFG] = '{10, 10, 10, 6, 10};

    logic clk;
    logic srstn;
    logic start;
    int   rmode;
    int   arm_id;
    int   gcyc;
    int   checks;
    int   errors;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s got %0d want %0d at %0t", g, nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        gcyc = 0;
        forever begin
            @(posedge clk);
            gcyc++;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : cfg
            localparam int K  = CFG_K[g];
            localparam int L  = CFG_L[g];
            localparam int N  = CFG_N[g];
            localparam int W  = CFG_W[g];
            localparam int V  = 10;
            localparam int TW = 4;

            pe_tile_sequencer_if #(.W_ADDR_WIDTH(W), .V_ADDR_WIDTH(V), .TILE_WIDTH(TW)) bus ();
            logic ready;
            int first_ren, last_ren, first_alu, last_alu, first_valid, first_done;
            int ndone, nhs, beat, addr64, addr95;

            assign bus.start        = start;
            assign bus.result_ready = ready;

            pe_tile_sequencer #(
                .ARRAY_SIZE(16), .K_ACCUM_DEPTH(K), .NUM_TILES(N), .SRAM_LATENCY(L),
                .W_ADDR_WIDTH(W), .V_ADDR_WIDTH(V), .TILE_WIDTH(TW)
            ) dut (
                .clk(clk),
                .srstn(srstn),
                .bus(bus)
            );

            // Per-config ready driver and event recorder for the literal checks.
            initial begin : drv
                int vrun;
                int my_arm;
                vrun = 0;
                my_arm = -1;
                ready = 1'b1;
                forever begin
                    @(negedge clk);
                    if (my_arm != arm_id) begin
                        my_arm = arm_id;
                        first_ren = -1; last_ren = -1; first_alu = -1; last_alu = -1;
                        first_valid = -1; first_done = -1;
                        ndone = 0; nhs = 0; beat = 0; addr64 = -1; addr95 = -1;
                    end
                    if (bus.sram_ren_w) begin
                        if (first_ren < 0) first_ren = gcyc;
                        last_ren = gcyc;
                        if (beat == 64) addr64 = int'(bus.sram_raddr_w);
                        if (beat == 95) addr95 = int'(bus.sram_raddr_w);
                        beat++;
                    end
                    if (bus.alu_start) begin
                        if (first_alu < 0) first_alu = gcyc;
                        last_alu = gcyc;
                    end
                    if (bus.result_valid && first_valid < 0) first_valid = gcyc;
                    if (bus.done) begin
                        ndone++;
                        if (first_done < 0) first_done = gcyc;
                    end
                    vrun = bus.result_valid ? vrun + 1 : 0;
                    case (rmode)
                        0:       ready = 1'b1;
                        1:       ready = ($urandom_range(0, 2) != 0);
                        default: ready = (vrun >= 6);
                    endcase
                    if (bus.result_valid && ready) nhs++;
                end
            end

            // Timeline model: a job is a run of tiles, each tile measured as an
            // offset from its clear cycle; the write phase lasts until accepted.
            initial begin : model
                int mode;      // 0 idle, 1 inside a tile, 2 done pulse
                int s, tile, cyc, o;
                bit rst_seen;
                bit e_busy, e_done, e_pe, e_ren, e_alu, e_valid;
                int e_aw, e_av, e_cn, e_tile;
                mode = 0; s = 0; tile = 0; cyc = 0; e_valid = 1'b0;
                forever begin
                    @(posedge clk);
                    cyc++;
                    rst_seen = !srstn;
                    if (rst_seen) begin
                        mode = 0;
                    end else begin
                        case (mode)
                            0: if (start) begin mode = 1; tile = 0; s = cyc; end
                            1: if (e_valid && ready) begin
                                   if (tile == N - 1) mode = 2;
                                   else begin tile++; s = cyc; end
                               end
                            default: mode = 0;
                        endcase
                    end
                    o = cyc - s;
                    e_busy = 0; e_done = 0; e_pe = 0; e_ren = 0; e_alu = 0; e_valid = 0;
                    e_aw = 0; e_av = 0; e_cn = 0; e_tile = 0;
                    if (!rst_seen) begin
                        e_busy = (mode != 0);
                        e_done = (mode == 2);
                        e_pe   = !(mode == 1 && o == 0);
                        if (mode == 1) begin
                            e_ren = (o >= 1 && o <= K);
                            if (e_ren) begin
                                e_aw = (tile * K + o - 1) % (1 << W);
                                e_av = (o - 1) % (1 << V);
                            end
                            e_alu   = (o >= 1 + L && o <= K + L);
                            e_cn    = e_alu ? o - 1 - L : 0;
                            e_valid = (o >= K + L + 3);
                            e_tile  = tile;
                        end
                    end
                    @(negedge clk);
                    chk("busy", g, int'(bus.busy), int'(e_busy));
                    chk("done", g, int'(bus.done), int'(e_done));
                    chk("pe_srstn", g, int'(bus.pe_srstn), int'(e_pe));
                    chk("ren_w", g, int'(bus.sram_ren_w), int'(e_ren));
                    chk("ren_v", g, int'(bus.sram_ren_v), int'(e_ren));
                    chk("alu_start", g, int'(bus.alu_start), int'(e_alu));
                    chk("cycle_num", g, int'(bus.cycle_num), e_cn);
                    chk("result_valid", g, int'(bus.result_valid), int'(e_valid));
                    if (e_ren) begin
                        chk("raddr_w", g, int'(bus.sram_raddr_w), e_aw);
                        chk("raddr_v", g, int'(bus.sram_raddr_v), e_av);
                    end
                    if (e_valid) chk("result_tile", g, int'(bus.result_tile), e_tile);
                end
            end
        end
    endgenerate

    // One job with result_ready tied high; timings are relative to the start cycle.
    task automatic pinned_job();
        int t0;
        @(negedge clk);
        start = 1'b1;
        t0 = gcyc;
        arm_id++;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        chk("pin_first_ren", 0, cfg[0].first_ren - t0, 2);
        chk("pin_last_ren", 0, cfg[0].last_ren - t0, 33);
        chk("pin_first_alu", 0, cfg[0].first_alu - t0, 3);
        chk("pin_last_alu", 0, cfg[0].last_alu - t0, 34);
        chk("pin_first_valid", 0, cfg[0].first_valid - t0, 37);
        chk("pin_done", 0, cfg[0].first_done - t0, 38);
        chk("pin_ndone", 0, cfg[0].ndone, 1);
        chk("pin_first_ren", 2, cfg[2].first_ren - t0, 2);
        chk("pin_first_alu", 2, cfg[2].first_alu - t0, 5);
        chk("pin_first_valid", 2, cfg[2].first_valid - t0, 39);
        chk("pin_done", 2, cfg[2].first_done - t0, 40);
        chk("pin_tile2_addr_first", 1, cfg[1].addr64, 64);
        chk("pin_tile2_addr_last", 1, cfg[1].addr95, 95);
        chk("pin_handshakes", 1, cfg[1].nhs, 3);
        chk("pin_done", 1, cfg[1].first_done - t0, 112);
        chk("pin_tile2_addr_wrap_first", 3, cfg[3].addr64, 0);
        chk("pin_tile2_addr_wrap_last", 3, cfg[3].addr95, 31);
        chk("pin_first_valid", 3, cfg[3].first_valid - t0, 38);
        chk("pin_done", 3, cfg[3].first_done - t0, 115);
        chk("pin_done", 4, cfg[4].first_done - t0, 15);
        chk("pin_handshakes", 4, cfg[4].nhs, 2);
    endtask

    initial begin
        int t0;
        checks = 0;
        errors = 0;
        srstn  = 1'b0;
        start  = 1'b0;
        rmode  = 0;
        arm_id = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, int'(cfg[0].bus.busy), 0);
        chk("rst_pe_srstn", 0, int'(cfg[0].bus.pe_srstn), 0);
        chk("rst_valid", 0, int'(cfg[0].bus.result_valid), 0);
        srstn = 1'b1;
        @(negedge clk);
        chk("idle_pe_srstn", 0, int'(cfg[0].bus.pe_srstn), 1);

        pinned_job();

        // Abort at the 10th fetch cycle, then a fresh job must repeat the timing.
        @(negedge clk);
        start = 1'b1;
        t0 = gcyc;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pre_addr_v", 0, int'(cfg[0].bus.sram_raddr_v), 9);
        chk("abort_pre_gap", 0, gcyc - t0, 11);
        srstn = 1'b0;
        @(negedge clk);
        srstn = 1'b1;
        chk("abort_busy", 0, int'(cfg[0].bus.busy), 0);
        chk("abort_ren", 0, int'(cfg[0].bus.sram_ren_w), 0);
        chk("abort_pe_srstn", 0, int'(cfg[0].bus.pe_srstn), 0);
        @(negedge clk);

        pinned_job();

        // Stalled writer (ready low 5 cycles per tile) with stray start pulses
        // mid-fetch and in cfg0's done cycle.
        rmode = 2;
        @(negedge clk);
        start = 1'b1;
        t0 = gcyc;
        arm_id++;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);
        chk("stall_done_cycle", 0, cfg[0].first_done - t0, 43);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (250) @(negedge clk);
        chk("stall_ndone", 0, cfg[0].ndone, 1);
        chk("stall_no_restart", 0, int'(cfg[0].bus.busy), 0);
        chk("stall_handshakes", 1, cfg[1].nhs, 3);
        chk("stall_ndone", 1, cfg[1].ndone, 1);
        chk("stall_tile2_addr", 1, cfg[1].addr64, 64);
        chk("stall_tile2_addr_wrap", 3, cfg[3].addr64, 0);

        // Random traffic: sparse start pulses, occasional resets, random ready.
        rmode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 24) == 0);
            srstn = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        srstn = 1'b1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
